// File: rtl/pci_pkg.sv
// Shared definitions for the PCI type-0 configuration target:
// bus command codes, target FSM states and config-space dword offsets.
package pci_pkg;

    localparam logic [3:0] PCI_CMD_CFG_READ  = 4'b1010;
    localparam logic [3:0] PCI_CMD_CFG_WRITE = 4'b1011;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLAIM,
        ST_DATA,
        ST_TURN,
        ST_BUSY
    } pci_state_e;

    // Dword offsets, i.e. AD[7:2] of the address phase
    localparam logic [5:0] CFG_OFF_ID    = 6'h00;
    localparam logic [5:0] CFG_OFF_CMD   = 6'h01;
    localparam logic [5:0] CFG_OFF_CLASS = 6'h02;
    localparam logic [5:0] CFG_OFF_HDR   = 6'h03;
    localparam logic [5:0] CFG_OFF_BAR0  = 6'h04;
    localparam logic [5:0] CFG_OFF_INT   = 6'h0F;

    function automatic logic [31:0] be_mask(input logic [3:0] be_n);
        return {{8{~be_n[3]}}, {8{~be_n[2]}}, {8{~be_n[1]}}, {8{~be_n[0]}}};
    endfunction

endpackage

// File: rtl/pci_cfg_regs.sv
// Type-0 header register file: identity constants, command bits,
// memory BARs and interrupt line, with byte-enable writes and read mux.
module pci_cfg_regs
    import pci_pkg::*;
#(
    parameter logic [15:0] VENDOR_ID     = 16'h5678,
    parameter logic [15:0] DEVICE_ID     = 16'h1234,
    parameter logic [7:0]  REVISION      = 8'h01,
    parameter logic [23:0] CLASS_CODE    = 24'hFF0000,
    parameter int          NUM_BARS      = 2,
    parameter int          BAR_SIZE_LOG2 = 12,
    parameter logic [7:0]  INT_PIN       = 8'h01
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_we,
    input  logic [5:0]               i_off,
    input  logic [31:0]              i_wdata,
    input  logic [3:0]               i_be_n,
    input  logic [5:0]               i_rd_off,
    output logic [31:0]              o_rdata,
    output logic [32*NUM_BARS-1:0]   o_bar_base,
    output logic                     o_io_en,
    output logic                     o_mem_en,
    output logic                     o_master_en
);

    localparam logic [31:0] BAR_MASK = ~((32'h1 << BAR_SIZE_LOG2) - 32'h1);

    logic [2:0]  r_cmd;
    logic [7:0]  r_intline;
    logic [31:0] r_bar [NUM_BARS];
    logic [31:0] w_bm;

    assign w_bm = be_mask(i_be_n);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cmd     <= '0;
            r_intline <= '0;
            for (int n = 0; n < NUM_BARS; n++) r_bar[n] <= '0;
        end else if (i_we) begin
            if (i_off == CFG_OFF_CMD && !i_be_n[0]) r_cmd <= i_wdata[2:0];
            if (i_off == CFG_OFF_INT && !i_be_n[0]) r_intline <= i_wdata[7:0];
            for (int n = 0; n < NUM_BARS; n++) begin
                if (i_off == CFG_OFF_BAR0 + 6'(n))
                    r_bar[n] <= ((r_bar[n] & ~w_bm) | (i_wdata & w_bm)) & BAR_MASK;
            end
        end
    end

    always_comb begin
        o_rdata = '0;
        unique case (i_rd_off)
            CFG_OFF_ID:    o_rdata = {DEVICE_ID, VENDOR_ID};
            CFG_OFF_CMD:   o_rdata = {29'h0, r_cmd};
            CFG_OFF_CLASS: o_rdata = {CLASS_CODE, REVISION};
            CFG_OFF_HDR:   o_rdata = '0;
            CFG_OFF_INT:   o_rdata = {16'h0, INT_PIN, r_intline};
            default: begin
                for (int n = 0; n < NUM_BARS; n++) begin
                    if (i_rd_off == CFG_OFF_BAR0 + 6'(n)) o_rdata = r_bar[n];
                end
            end
        endcase
    end

    for (genvar g = 0; g < NUM_BARS; g++) begin : g_bar
        assign o_bar_base[32*g +: 32] = r_bar[g];
    end

    assign o_io_en     = r_cmd[0];
    assign o_mem_en    = r_cmd[1];
    assign o_master_en = r_cmd[2];

endmodule

// File: rtl/pci_cfg_target.sv
// PCI type-0 configuration target: fast-DEVSEL# claim FSM, registered
// read data and parity, bus output enables around pci_cfg_regs.
module pci_cfg_target
    import pci_pkg::*;
#(
    parameter logic [15:0] VENDOR_ID     = 16'h5678,
    parameter logic [15:0] DEVICE_ID     = 16'h1234,
    parameter logic [7:0]  REVISION      = 8'h01,
    parameter logic [23:0] CLASS_CODE    = 24'hFF0000,
    parameter int          NUM_BARS      = 2,
    parameter int          BAR_SIZE_LOG2 = 12,
    parameter logic [7:0]  INT_PIN       = 8'h01
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [31:0]            ad_i,
    output logic [31:0]            ad_o,
    output logic                   ad_oe,
    input  logic [3:0]             cbe_i,
    output logic                   par_o,
    output logic                   par_oe,
    input  logic                   frame_i,
    input  logic                   irdy_i,
    input  logic                   idsel,
    output logic                   trdy_o,
    output logic                   stop_o,
    output logic                   devsel_o,
    output logic                   ctl_oe,
    output logic [32*NUM_BARS-1:0] bar_base,
    output logic                   io_en,
    output logic                   mem_en,
    output logic                   master_en
);

    pci_state_e  r_state;
    logic        r_frame_q;
    logic [5:0]  r_off;
    logic        r_wr;
    logic [31:0] r_rdata;
    logic        r_par;
    logic        r_par_oe;

    logic        w_addr;
    logic        w_cmd_ok;
    logic        w_claim;
    logic        w_we;
    logic [5:0]  w_rd_off;
    logic [31:0] w_reg_rdata;

    assign w_addr   = !frame_i && r_frame_q;
    assign w_cmd_ok = (cbe_i == PCI_CMD_CFG_READ) || (cbe_i == PCI_CMD_CFG_WRITE);
    assign w_claim  = (r_state == ST_IDLE) && w_addr && idsel && w_cmd_ok
                      && (ad_i[1:0] == 2'b00) && (ad_i[10:8] == 3'b000);
    assign w_we     = (r_state == ST_DATA) && !irdy_i && r_wr;
    // Look up with the live address so read data is ready in CLAIM
    assign w_rd_off = w_claim ? ad_i[7:2] : r_off;

    pci_cfg_regs #(
        .VENDOR_ID     (VENDOR_ID),
        .DEVICE_ID     (DEVICE_ID),
        .REVISION      (REVISION),
        .CLASS_CODE    (CLASS_CODE),
        .NUM_BARS      (NUM_BARS),
        .BAR_SIZE_LOG2 (BAR_SIZE_LOG2),
        .INT_PIN       (INT_PIN)
    ) u_regs (
        .i_clk       (clk),
        .i_rst_n     (rst),
        .i_we        (w_we),
        .i_off       (r_off),
        .i_wdata     (ad_i),
        .i_be_n      (cbe_i),
        .i_rd_off    (w_rd_off),
        .o_rdata     (w_reg_rdata),
        .o_bar_base  (bar_base),
        .o_io_en     (io_en),
        .o_mem_en    (mem_en),
        .o_master_en (master_en)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_frame_q <= 1'b1;
            r_off     <= '0;
            r_wr      <= 1'b0;
            r_rdata   <= '0;
            r_par     <= 1'b0;
            r_par_oe  <= 1'b0;
        end else begin
            r_frame_q <= frame_i;
            r_par     <= ^{ad_o, cbe_i};
            r_par_oe  <= ad_oe;
            if (w_claim) begin
                r_off   <= ad_i[7:2];
                r_wr    <= cbe_i[0];
                r_rdata <= w_reg_rdata;
            end
            unique case (r_state)
                ST_IDLE: begin
                    if (w_claim)     r_state <= ST_CLAIM;
                    else if (w_addr) r_state <= ST_BUSY;
                end
                ST_CLAIM: r_state <= ST_DATA;
                ST_DATA:  if (!irdy_i) r_state <= ST_TURN;
                ST_TURN:  r_state <= frame_i ? ST_IDLE : ST_BUSY;
                ST_BUSY:  if (frame_i && irdy_i) r_state <= ST_IDLE;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        devsel_o = 1'b1;
        trdy_o   = 1'b1;
        stop_o   = 1'b1;
        ctl_oe   = 1'b0;
        ad_oe    = 1'b0;
        unique case (r_state)
            ST_CLAIM: begin
                devsel_o = 1'b0;
                ctl_oe   = 1'b1;
                ad_oe    = !r_wr;
            end
            ST_DATA: begin
                devsel_o = 1'b0;
                trdy_o   = 1'b0;
                stop_o   = frame_i;
                ctl_oe   = 1'b1;
                ad_oe    = !r_wr;
            end
            ST_TURN: ctl_oe = 1'b1;
            default: ctl_oe = 1'b0;
        endcase
    end

    assign ad_o   = r_rdata;
    assign par_o  = r_par;
    assign par_oe = r_par_oe;

endmodule
